// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, one bit per clock, LSB first.
// A start in IDLE loads the operands, WIDTH SHIFT cycles form the result,
// and a single DONE cycle pulses done before returning to IDLE.
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN adds the signed-overflow
// output ovf. The default build (macro undefined) has no ovf port.
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  // Counter wide enough to hold WIDTH-1 for any legal WIDTH
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_reg;
  logic [CW-1:0]    cnt_reg;

  // Current bit pair and the full-subtractor cell that consumes it
  logic a_bit;
  logic b_bit;
  logic d_bit;
  logic borrow_next;
  logic last_bit;

  assign a_bit       = a_reg[0];
  assign b_bit       = b_reg[0];
  assign d_bit       = a_bit ^ b_bit ^ borrow_reg;
  assign borrow_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_reg);
  assign last_bit    = (cnt_reg == CW'(WIDTH - 1));

  assign diff       = diff_reg;
  assign borrow_out = borrow_reg;

  // State register; reset overrides any pending start or running operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and status outputs
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand, result, borrow and counter datapath; results hold in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg      <= '0;
      b_reg      <= '0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg      <= a;
            b_reg      <= b;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
          end
        end
        SHIFT: begin
          a_reg      <= a_reg >> 1;
          b_reg      <= b_reg >> 1;
          diff_reg   <= {d_bit, diff_reg[WIDTH-1:1]};
          borrow_reg <= borrow_next;
          cnt_reg    <= cnt_reg + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic ovf_reg;

  assign ovf = ovf_reg;

  // Signed overflow, judged on the MSB cell (the last bit processed)
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == IDLE && start) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == SHIFT && last_bit) begin
      ovf_reg <= (a_bit != b_bit) && (d_bit != a_bit);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8.
// Expected results are pushed to a queue when a start is driven and popped
// when done is observed. Build with SERIAL_SUB_OVERFLOW_EN to check ovf.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] d;
    logic         bw;
    logic         ov;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   fails;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t make_exp(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    e.d  = av - bv;
    e.bw = (av < bv);
    e.ov = (av[W-1] != bv[W-1]) && (e.d[W-1] != av[W-1]);
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    a     = 8'h55;
    b     = 8'h11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    checks++;
    if (diff !== 8'h00) begin fails++; $display("FAIL reset_diff got %h want 00", diff); end
    checks++;
    if (borrow_out !== 1'b0) begin fails++; $display("FAIL reset_borrow got %b want 0", borrow_out); end
`ifdef SERIAL_SUB_OVERFLOW_EN
    checks++;
    if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_start_ignored busy got %b want 0", busy); end
    $display("test_reset: done");
  endtask

  // One subtraction: checks latency, result, done width and result hold.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input string name);
    int   n;
    exp_t e;
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    exp_q.push_back(make_exp(av, bv));
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start = 1'b0;
    a     = ~av;
    b     = ~bv;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 4) start = 1'b1;
      if (n == 5) start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
    end
    checks++;
    if (n != W + 1) begin
      fails++;
      $display("FAIL %s_latency got %0d edges want %0d", name, n, W + 1);
    end
    if (done !== 1'b1) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (diff !== e.d) begin fails++; $display("FAIL %s_diff got %h want %h", name, diff, e.d); end
    checks++;
    if (borrow_out !== e.bw) begin fails++; $display("FAIL %s_borrow got %b want %b", name, borrow_out, e.bw); end
`ifdef SERIAL_SUB_OVERFLOW_EN
    checks++;
    if (ovf !== e.ov) begin fails++; $display("FAIL %s_ovf got %b want %b", name, ovf, e.ov); end
`endif
    checks++;
    if (busy !== 1'b1) begin fails++; $display("FAIL %s_busy_in_done got %b want 1", name, busy); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_after_done got done=%b busy=%b want done=0 busy=0", name, done, busy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (diff !== e.d || borrow_out !== e.bw) begin
      fails++;
      $display("FAIL %s_hold got diff=%h borrow=%b want diff=%h borrow=%b", name, diff, borrow_out, e.d, e.bw);
    end
    $display("%s: a=%h b=%h diff=%h borrow=%b latency=%0d", name, av, bv, diff, borrow_out, n);
  endtask

  task automatic test_basic();
    run_op(8'h05, 8'h03, "sub_5_3");
    run_op(8'h03, 8'h05, "sub_3_5");
    run_op(8'h80, 8'h01, "sub_80_01");
    run_op(8'h7F, 8'hFF, "sub_7f_ff");
  endtask

  task automatic test_boundary();
    run_op(8'h00, 8'h00, "sub_0_0");
    run_op(8'h00, 8'hFF, "sub_0_ff");
    run_op(8'hA5, 8'hA5, "sub_eq");
    run_op(8'hFF, 8'h00, "sub_ff_0");
  endtask

  // start held high with operands changing every cycle: results every W+2 cycles
  task automatic test_back_to_back();
    int   results;
    exp_t e;
    results = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (k % (W + 2) == 0) exp_q.push_back(make_exp(a, b));
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (done !== (k % (W + 2) == W)) begin
        fails++;
        $display("FAIL b2b_done_timing k=%0d got %b want %b", k, done, (k % (W + 2) == W));
      end
      checks++;
      if (busy !== (k % (W + 2) != W + 1)) begin
        fails++;
        $display("FAIL b2b_busy k=%0d got %b want %b", k, busy, (k % (W + 2) != W + 1));
      end
      if (done === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        results++;
        checks++;
        if (diff !== e.d || borrow_out !== e.bw) begin
          fails++;
          $display("FAIL b2b_result k=%0d got diff=%h borrow=%b want diff=%h borrow=%b", k, diff, borrow_out, e.d, e.bw);
        end
`ifdef SERIAL_SUB_OVERFLOW_EN
        checks++;
        if (ovf !== e.ov) begin fails++; $display("FAIL b2b_ovf k=%0d got %b want %b", k, ovf, e.ov); end
`endif
        $display("b2b: result %0d at k=%0d diff=%h borrow=%b", results, k, diff, borrow_out);
      end
    end
    start = 1'b0;
    checks++;
    if (results != 4 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL b2b_count got %0d results (%0d pending) want 4 (0 pending)", results, exp_q.size());
    end
    exp_q.delete();
    repeat (3) @(posedge clk);
  endtask

  // Reset during the 4th SHIFT cycle aborts the operation with no done
  task automatic test_reset_mid();
    int seen;
    seen = 0;
    @(negedge clk);
    a     = 8'h00;
    b     = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy_before got %b want 1", busy); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++;
    if (diff !== 8'h00 || borrow_out !== 1'b0) begin
      fails++;
      $display("FAIL abort_clear got diff=%h borrow=%b want diff=00 borrow=0", diff, borrow_out);
    end
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin fails++; $display("FAIL abort_no_done got %0d active cycles want 0", seen); end
    $display("test_reset_mid: aborted, busy=%b diff=%h", busy, diff);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    test_reset();
    test_basic();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    run_op(8'h12, 8'h34, "after_abort");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand/result width in bits; legal range 2..64.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset; sampled only on the rising edge of clk.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction; sampled on the clk edge.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend; captured when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend; captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking that diff, borrow_out and ovf are valid.
REQ-009 The block SHALL have port diff, output, WIDTH bits: a minus b, modulo 2^WIDTH.
REQ-010 The block SHALL have port borrow_out, output, 1 bit: set when unsigned a < unsigned b.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, SHIFT and DONE.
REQ-012 In IDLE, start=1 SHALL be accepted and SHALL cause the following on the same edge: load a and b into internal shift registers; clear the borrow flip-flop; clear the bit counter; clear the diff shift register; enter SHIFT.
REQ-013 Each SHIFT cycle SHALL process one bit, LSB first.
REQ-014 The bit processed in each SHIFT cycle SHALL satisfy d = a_i XOR b_i XOR bw.
REQ-015 The next borrow SHALL be bw' = (~a_i & b_i) | (~(a_i ^ b_i) & bw).
REQ-016 In each SHIFT cycle, d SHALL shift into the diff register from the MSB side, the operand registers SHALL shift right, and the counter SHALL increment.
REQ-017 After exactly WIDTH SHIFT cycles the FSM SHALL enter DONE.
REQ-018 On entering DONE, diff SHALL hold the complete result and borrow_out SHALL hold the final borrow.
REQ-019 done SHALL be high for exactly one cycle, while in DONE.
REQ-020 From DONE the FSM SHALL return to IDLE unconditionally on the next edge.
REQ-021 Latency SHALL be fixed: done is high in the cycle that begins WIDTH+1 edges after the edge that sampled start.
REQ-022 busy SHALL be high in SHIFT and DONE and low in IDLE.
REQ-023 start SHALL be ignored while in SHIFT or DONE; no restart and no state corruption.
REQ-024 Inputs a and b SHALL be ignored except on the accepting edge; changes during SHIFT SHALL not affect the result.
REQ-025 diff, borrow_out and ovf SHALL hold their last values in IDLE until the next accepted start clears them.
REQ-026 a == b SHALL produce diff=0 and borrow_out=0.
REQ-027 Wrap-around SHALL be modulo 2^WIDTH with no saturation.

Reset
REQ-028 reset=1 SHALL force the FSM to IDLE and clear busy, done, diff, borrow_out, ovf, the counter and the internal registers to 0 on the next edge.
REQ-029 reset SHALL take priority over start and over any in-progress operation; a reset mid-SHIFT SHALL abort the operation, and no done SHALL follow.
REQ-030 start asserted together with reset SHALL be ignored.

Configuration
REQ-031 With macro SERIAL_SUB_OVERFLOW_EN defined, the block SHALL add output port ovf, 1 bit.
REQ-032 With SERIAL_SUB_OVERFLOW_EN defined, ovf SHALL be set in DONE when the two's-complement subtraction overflows, computed as (a_msb != b_msb) && (d_msb != a_msb).
REQ-033 With SERIAL_SUB_OVERFLOW_EN defined, ovf SHALL obey the same reset and hold rules as borrow_out.
REQ-034 Without SERIAL_SUB_OVERFLOW_EN, the ovf port and its logic SHALL be absent, with no other behavioural change.

Verification (WIDTH=8)
REQ-035 The bench SHALL cover: a=0x05, b=0x03, start pulse -> done 9 cycles later, diff=0x02, borrow_out=0, ovf=0.
REQ-036 The bench SHALL cover: a=0x03, b=0x05 -> diff=0xFE, borrow_out=1, ovf=0.
REQ-037 The bench SHALL cover: a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, ovf=1 when the macro is defined.
REQ-038 The bench SHALL cover: a=0x00, b=0x00 -> diff=0x00, borrow_out=0; then a=0x00, b=0xFF -> diff=0x01, borrow_out=1.
REQ-039 The bench SHALL cover: start held high continuously with a and b changing every cycle -> one result per 10 cycles, each equal to the operands sampled in IDLE.
REQ-040 The bench SHALL cover: reset pulsed on the 4th SHIFT cycle -> busy=0 and diff=0 the next cycle, and no done pulse.
